// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller of the 5-stage MIPS core.
//   state_t   : pipeline sequencing FSM states (IDLE / MEM_WAIT / HALT)
//   fwd_sel_t : E-stage forwarding select encodings (regfile / W result / M ALU result)
//   reg_match : register dependency test; $0 never creates a hazard or a forward
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  function automatic logic reg_match(input logic [4:0] x, input logic [4:0] y);
    return (x == y) && (y != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_forwarding_unit.sv
// Pure combinational forwarding select for the D and E stages.
//   rs_d, rt_d, rs_e, rt_e : source registers in Decode / Execute
//   write_reg_m/_w, rfwe_m/_w : destination and write enable in Memory / Writeback
//   fwd_a_d, fwd_b_d       : 1 = D-stage compare takes the M-stage ALU result
//   fwd_a_e, fwd_b_e       : E-stage ALU operand select (fwd_sel_t encoding)
module hazard_stall_controller_forwarding_unit
  import hazard_stall_controller_pkg::*;
(
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       rfwe_m,
  input  logic       rfwe_w,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e
);

  // The M stage holds the younger result, so it wins when M and W both match.
  function automatic fwd_sel_t sel_e(input logic [4:0] src);
    if (rfwe_m && reg_match(write_reg_m, src)) return FWD_M;
    if (rfwe_w && reg_match(write_reg_w, src)) return FWD_W;
    return FWD_RF;
  endfunction

  assign fwd_a_e = sel_e(rs_e);
  assign fwd_b_e = sel_e(rt_e);
  assign fwd_a_d = rfwe_m && reg_match(write_reg_m, rs_d);
  assign fwd_b_d = rfwe_m && reg_match(write_reg_m, rt_d);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use / branch-operand hazard detection, per-stage
// stall and flush, D/E forwarding selects, and a freeze while data memory withholds dm_ready.
// A watchdog halts the core after MEM_TIMEOUT consecutive not-ready cycles.
//   clk, rst                 : clock, synchronous active-high reset
//   rs_*/rt_*/write_reg_*    : pipeline-register register fields
//   rfwe_*, mtorfsel_*       : write enable / load flags carried down the pipe
//   branch_d, jump_d, pcsrc_d: control-flow info from Decode
//   dm_access_m, dm_ready    : data memory handshake
//   stall_*, flush_*         : pipeline register hold / bubble controls
//   fwd_*                    : forwarding selects
//   mem_err                  : sticky memory timeout flag
//   stall_cycles             : saturating count of cycles with stall_f=1
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       write_reg_e,
  input  logic [4:0]       write_reg_m,
  input  logic [4:0]       write_reg_w,
  input  logic             rfwe_e,
  input  logic             rfwe_m,
  input  logic             rfwe_w,
  input  logic             mtorfsel_e,
  input  logic             mtorfsel_m,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             pcsrc_d,
  input  logic             dm_access_m,
  input  logic             dm_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;

  logic mem_hold, freeze, lwstall, brstall, hz;
  logic fu_fwd_a_d, fu_fwd_b_d;
  logic [1:0] fu_fwd_a_e, fu_fwd_b_e;

  hazard_stall_controller_forwarding_unit u_fwd (
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .write_reg_m (write_reg_m),
    .write_reg_w (write_reg_w),
    .rfwe_m      (rfwe_m),
    .rfwe_w      (rfwe_w),
    .fwd_a_d     (fu_fwd_a_d),
    .fwd_b_d     (fu_fwd_b_d),
    .fwd_a_e     (fu_fwd_a_e),
    .fwd_b_e     (fu_fwd_b_e)
  );

  // Freeze uses mem_hold directly so the pipe stops in the very cycle memory stalls.
  assign mem_hold = dm_access_m && !dm_ready;
  assign freeze   = mem_hold || (state == ST_HALT);

  assign lwstall = mtorfsel_e && rfwe_e &&
                   (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d));
  assign brstall = branch_d &&
                   ((rfwe_e && (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d))) ||
                    (mtorfsel_m && (reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d))));
  assign hz      = lwstall || brstall;

  // Priority: reset forces everything quiet, then freeze, then hazard, then control-flow flush.
  // NOTE: every output of this always_comb gets a default first so no path can infer a latch.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_d = pcsrc_d || jump_d;
      end
    end
  end

  // Forwards stay live during freeze; frozen stages simply ignore them.
  assign fwd_a_d = rst ? 1'b0 : fu_fwd_a_d;
  assign fwd_b_d = rst ? 1'b0 : fu_fwd_b_d;
  assign fwd_a_e = rst ? FWD_RF : fu_fwd_a_e;
  assign fwd_b_e = rst ? FWD_RF : fu_fwd_b_e;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (mem_hold) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dm_ready) begin
          state_next    = ST_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next = ST_HALT;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state_next == ST_HALT) mem_err <= 1'b1;
      if (stall_f && (stall_cycles != {CNT_W{1'b1}})) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic rfwe_e, rfwe_m, rfwe_w, mtorfsel_e, mtorfsel_m;
  logic branch_d, jump_d, pcsrc_d, dm_access_m, dm_ready;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic fwd_a_d, fwd_b_d, mem_err;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [31:0] stall_cycles;

  typedef struct {
    string       name;
    int          step;
    logic [13:0] v;
    logic [31:0] cnt;
    bit          is_rst;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_cnt = 0;

  hazard_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .rfwe_e(rfwe_e), .rfwe_m(rfwe_m), .rfwe_w(rfwe_w),
    .mtorfsel_e(mtorfsel_e), .mtorfsel_m(mtorfsel_m),
    .branch_d(branch_d), .jump_d(jump_d), .pcsrc_d(pcsrc_d),
    .dm_access_m(dm_access_m), .dm_ready(dm_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // Packs expected outputs: {stall f,d,e,m, flush d,e,w, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mem_err}
  function automatic logic [13:0] mk(input logic sf, sd, se, sm, fd, fe, fw, fad, fbd,
                                      input logic [1:0] fae, fbe, input logic me);
    return {sf, sd, se, sm, fd, fe, fw, fad, fbd, fae, fbe, me};
  endfunction

  function automatic logic [13:0] obs();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
            fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mem_err};
  endfunction

  task automatic clear_inputs();
    rst = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    rfwe_e = 0; rfwe_m = 0; rfwe_w = 0; mtorfsel_e = 0; mtorfsel_m = 0;
    branch_d = 0; jump_d = 0; pcsrc_d = 0; dm_access_m = 0; dm_ready = 0;
  endtask

  // Expected counter after a popped step: reset clears it, a stall_f cycle adds one.
  task automatic advance_cnt(input exp_t x);
    if (x.is_rst) exp_cnt = 0;
    else if (x.v[13]) exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    logic [13:0] ev;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      // Hazard and memory-hold inputs active while in reset: all must stay quiet.
      rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 8; rs_d = 8;
      dm_access_m = 1; jump_d = 1;
      ev = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0);
      if (s < 2) rst = 1;
      else begin
        dm_access_m = 0; jump_d = 0; rfwe_e = 0;
      end
      sbq.push_back('{name: "reset", step: s, v: ev, cnt: exp_cnt, is_rst: rst});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  task automatic test_lw_use();
    logic [13:0] ev;
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (s)
        0: begin rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 8; rs_d = 8;
                  ev = mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0); end
        1: begin rfwe_m = 1; mtorfsel_m = 1; write_reg_m = 8; rs_d = 8;
                  ev = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,0); end
        2: begin rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 0; rs_d = 0;
                  ev = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0); end
        default: begin rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 9; rt_d = 9;
                  ev = mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0); end
      endcase
      sbq.push_back('{name: "lw_use", step: s, v: ev, cnt: exp_cnt, is_rst: 0});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  task automatic test_forward();
    logic [13:0] ev;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (s)
        0: begin rfwe_m = 1; write_reg_m = 5; rfwe_w = 1; write_reg_w = 5; rs_e = 5;
                  ev = mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0); end
        1: begin rfwe_m = 0; write_reg_m = 5; rfwe_w = 1; write_reg_w = 5; rs_e = 5;
                  ev = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,0); end
        2: begin rfwe_m = 1; write_reg_m = 0; rfwe_w = 1; write_reg_w = 0; rs_e = 0;
                  ev = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0); end
        3: begin rfwe_w = 1; write_reg_w = 7; rs_e = 7; rt_e = 7;
                  ev = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b01,0); end
        default: begin rfwe_m = 1; write_reg_m = 7; rfwe_w = 1; write_reg_w = 7;
                  rs_e = 7; rt_e = 7; rt_d = 7;
                  ev = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b10,0); end
      endcase
      sbq.push_back('{name: "forward", step: s, v: ev, cnt: exp_cnt, is_rst: 0});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  task automatic test_branch();
    logic [13:0] ev;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (s)
        // Load in M feeding beq in D: stall, forward select still computed.
        0: begin branch_d = 1; rs_d = 3; rfwe_m = 1; mtorfsel_m = 1; write_reg_m = 3;
                  ev = mk(1,1,0,0,0,1,0,1,0,2'b00,2'b00,0); end
        // Load reached W: no stall, no D forward, taken branch flushes D.
        1: begin branch_d = 1; rs_d = 3; pcsrc_d = 1; rfwe_w = 1; write_reg_w = 3;
                  ev = mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,0); end
        // ALU result in E feeding rt of beq: stall beats the taken-branch flush.
        default: begin branch_d = 1; rt_d = 4; pcsrc_d = 1; rfwe_e = 1; write_reg_e = 4;
                  ev = mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0); end
      endcase
      sbq.push_back('{name: "branch", step: s, v: ev, cnt: exp_cnt, is_rst: 0});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  task automatic test_jump();
    logic [13:0] ev;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      jump_d = 1; rs_d = 6;
      if (s == 0) begin
        rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 6;
        ev = mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0);
      end else begin
        rfwe_m = 1; mtorfsel_m = 1; write_reg_m = 6;
        ev = mk(0,0,0,0,1,0,0,1,0,2'b00,2'b00,0);
      end
      sbq.push_back('{name: "jump", step: s, v: ev, cnt: exp_cnt, is_rst: 0});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  task automatic test_mem_wait();
    logic [13:0] ev;
    for (int s = 0; s < 7; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      rfwe_m = 1; write_reg_m = 2; rs_e = 2;
      dm_access_m = 1;
      if (s < 3) begin
        // Load-use hazard and jump present too: freeze must mask them.
        rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 8; rs_d = 8; jump_d = 1;
        ev = mk(1,1,1,1,0,0,1,0,0,2'b10,2'b00,0);
      end else if (s == 3) begin
        dm_ready = 1;
        ev = mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
      end else if (s == 4) begin
        dm_access_m = 0;
        ev = mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
      end else if (s == 5) begin
        ev = mk(1,1,1,1,0,0,1,0,0,2'b10,2'b00,0);
      end else begin
        dm_ready = 1;
        ev = mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
      end
      sbq.push_back('{name: "mem_wait", step: s, v: ev, cnt: exp_cnt, is_rst: 0});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  task automatic test_timeout();
    logic [13:0] ev;
    for (int s = 0; s < 22; s++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (s <= 15) begin
        dm_access_m = 1;
        ev = mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,0);
      end else if (s == 16) begin
        dm_ready = 1;
        ev = mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,1);
      end else if (s == 17) begin
        dm_ready = 1; jump_d = 1; rfwe_e = 1; mtorfsel_e = 1; write_reg_e = 4; rs_d = 4;
        ev = mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,1);
      end else if (s == 18) begin
        rst = 1; dm_access_m = 1;
        ev = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,1);
      end else if (s == 19) begin
        ev = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0);
      end else if (s == 20) begin
        dm_access_m = 1;
        ev = mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,0);
      end else begin
        dm_access_m = 1; dm_ready = 1;
        ev = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0);
      end
      sbq.push_back('{name: "timeout", step: s, v: ev, cnt: exp_cnt, is_rst: rst});
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (obs() !== e.v || stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL %s[%0d]: got out=%b cnt=%0d want out=%b cnt=%0d", e.name, e.step, obs(), stall_cycles, e.v, e.cnt);
      end
      advance_cnt(e);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_lw_use();
    test_forward();
    test_branch();
    test_jump();
    test_mem_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
